// File: rtl/alu_issue.sv
// alu_issue: decode/issue stage feeding a 64-bit integer ALU; owns the 32x64 register file.
// Build macro ALU_ISSUE_FWD_EN forwards alu_data from the E1 stage (one-bubble dependency).
module alu_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst_in,
    input  logic        inst_valid,
    output logic        inst_ready,
    output logic [4:0]  regA,
    output logic [11:0] regB,
    output logic [9:0]  opcode,
    output logic [4:0]  regDest,
    output logic [63:0] regA_value,
    output logic [63:0] regB_value,
    input  logic [63:0] alu_data,
    input  logic        alu_wr_en,
    output logic        illegal,
    output logic        retire,
    output logic [4:0]  retire_rd
);
    localparam int unsigned XLEN = 64;
    localparam int unsigned NREGS = 32;
    localparam logic [9:0] NopOpcode = 10'h013;

    typedef enum logic [0:0] {StRun, StStall} state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0] rf_q [NREGS];

    logic [4:0]      reg_a_q, reg_a_d;
    logic [11:0]     reg_b_q, reg_b_d;
    logic [9:0]      opcode_q, opcode_d;
    logic [4:0]      reg_dest_q, reg_dest_d;
    logic [XLEN-1:0] reg_a_value_q, reg_a_value_d;
    logic [XLEN-1:0] reg_b_value_q, reg_b_value_d;
    logic            illegal_q, illegal_d;
    logic            retire_q, retire_d;
    logic [4:0]      retire_rd_q, retire_rd_d;
    // Writeback pipe: wb0 holds the instruction now in the ALU, wb1 the one whose result is ready.
    logic            wb0_vld_q, wb0_vld_d, wb1_vld_q, wb1_vld_d;
    logic [4:0]      wb0_rd_q, wb0_rd_d, wb1_rd_q, wb1_rd_d;

    logic [6:0]      op7;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2, rd;
    logic            rtype, legal, busy_rs1, busy_rs2, hazard, accept, issue_ok;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            unused_wr_en;

    assign unused_wr_en = alu_wr_en;

    assign op7    = inst_in[6:0];
    assign funct3 = inst_in[14:12];
    assign rd     = inst_in[11:7];
    assign rs1    = inst_in[19:15];
    assign rs2    = inst_in[24:20];
    assign rtype  = (op7 == 7'h33) || (op7 == 7'h3b);
    assign legal  = rtype || (op7 == 7'h13) || (op7 == 7'h1b);

    // Busy is derived from the writeback pipe, so a back-to-back rewrite keeps it held.
    always_comb begin
`ifdef ALU_ISSUE_FWD_EN
        busy_rs1 = (rs1 != 5'd0) && wb0_vld_q && (wb0_rd_q == rs1);
        busy_rs2 = (rs2 != 5'd0) && wb0_vld_q && (wb0_rd_q == rs2);
`else
        busy_rs1 = (rs1 != 5'd0) && ((wb0_vld_q && (wb0_rd_q == rs1)) ||
                                     (wb1_vld_q && (wb1_rd_q == rs1)));
        busy_rs2 = (rs2 != 5'd0) && ((wb0_vld_q && (wb0_rd_q == rs2)) ||
                                     (wb1_vld_q && (wb1_rd_q == rs2)));
`endif
    end

    assign hazard = inst_valid && legal && (busy_rs1 || (rtype && busy_rs2));

    // Write-first read: a register being written this edge reads as alu_data.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0) begin
            rs1_val = (wb1_vld_q && (wb1_rd_q == rs1)) ? alu_data : rf_q[rs1];
        end
        if (rs2 != 5'd0) begin
            rs2_val = (wb1_vld_q && (wb1_rd_q == rs2)) ? alu_data : rf_q[rs2];
        end
    end

    always_comb begin
        state_d    = state_q;
        inst_ready = 1'b0;
        unique case (state_q)
            StRun: begin
                inst_ready = !reset && !hazard;
                if (hazard) state_d = StStall;
            end
            StStall: begin
                inst_ready = !reset && !hazard;
                if (!hazard) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    assign accept   = inst_valid && inst_ready;
    assign issue_ok = accept && legal;

    always_comb begin
        reg_a_d       = 5'd0;
        reg_b_d       = 12'd0;
        opcode_d      = NopOpcode;
        reg_dest_d    = 5'd0;
        reg_a_value_d = '0;
        reg_b_value_d = '0;
        wb0_vld_d     = issue_ok;
        wb0_rd_d      = 5'd0;
        if (issue_ok) begin
            reg_a_d       = rs1;
            reg_b_d       = inst_in[31:20];
            opcode_d      = {funct3, op7};
            reg_dest_d    = rd;
            reg_a_value_d = rs1_val;
            reg_b_value_d = rtype ? rs2_val : '0;
            wb0_rd_d      = rd;
        end
        illegal_d   = accept && !legal;
        wb1_vld_d   = wb0_vld_q;
        wb1_rd_d    = wb0_rd_q;
        retire_d    = wb1_vld_q;
        retire_rd_d = wb1_vld_q ? wb1_rd_q : 5'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StRun;
            reg_a_q       <= 5'd0;
            reg_b_q       <= 12'd0;
            opcode_q      <= NopOpcode;
            reg_dest_q    <= 5'd0;
            reg_a_value_q <= '0;
            reg_b_value_q <= '0;
            illegal_q     <= 1'b0;
            retire_q      <= 1'b0;
            retire_rd_q   <= 5'd0;
            wb0_vld_q     <= 1'b0;
            wb0_rd_q      <= 5'd0;
            wb1_vld_q     <= 1'b0;
            wb1_rd_q      <= 5'd0;
        end else begin
            state_q       <= state_d;
            reg_a_q       <= reg_a_d;
            reg_b_q       <= reg_b_d;
            opcode_q      <= opcode_d;
            reg_dest_q    <= reg_dest_d;
            reg_a_value_q <= reg_a_value_d;
            reg_b_value_q <= reg_b_value_d;
            illegal_q     <= illegal_d;
            retire_q      <= retire_d;
            retire_rd_q   <= retire_rd_d;
            wb0_vld_q     <= wb0_vld_d;
            wb0_rd_q      <= wb0_rd_d;
            wb1_vld_q     <= wb1_vld_d;
            wb1_rd_q      <= wb1_rd_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (wb1_vld_q && (wb1_rd_q != 5'd0)) begin
            rf_q[wb1_rd_q] <= alu_data;
        end
    end

    assign regA       = reg_a_q;
    assign regB       = reg_b_q;
    assign opcode     = opcode_q;
    assign regDest    = reg_dest_q;
    assign regA_value = reg_a_value_q;
    assign regB_value = reg_b_value_q;
    assign illegal    = illegal_q;
    assign retire     = retire_q;
    assign retire_rd  = retire_rd_q;
endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: decode table, directed hazard/reset sequences and random
// instruction streams checked against an in-order architectural model; ALU stub lives here.
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst_in;
    logic        inst_valid;
    logic        inst_ready;
    logic [4:0]  regA;
    logic [11:0] regB;
    logic [9:0]  opcode;
    logic [4:0]  regDest;
    logic [63:0] regA_value, regB_value;
    logic [63:0] alu_data = '0;
    logic        illegal, retire;
    logic [4:0]  retire_rd;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

`ifdef ALU_ISSUE_FWD_EN
    localparam int DepStalls = 1;
`else
    localparam int DepStalls = 2;
`endif

    alu_issue dut (
        .clk(clk), .reset(reset), .inst_in(inst_in), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .regA(regA), .regB(regB), .opcode(opcode),
        .regDest(regDest), .regA_value(regA_value), .regB_value(regB_value),
        .alu_data(alu_data), .alu_wr_en(1'b1), .illegal(illegal), .retire(retire),
        .retire_rd(retire_rd)
    );

    always #5 clk = ~clk;

    // Reference ALU semantics, shared by the ALU stub and the architectural model.
    function automatic logic [63:0] alu_fn(input logic [9:0] opc, input logic [11:0] rb,
                                           input logic [63:0] a, input logic [63:0] bv);
        logic [6:0]  op;
        logic        r;
        logic [63:0] b, res;
        op = opc[6:0];
        r = (op == 7'h33) || (op == 7'h3b);
        b = r ? bv : {{52{rb[11]}}, rb};
        case (opc[9:7])
            3'd0:    res = (r && rb[10]) ? a - b : a + b;
            3'd4:    res = a ^ b;
            3'd6:    res = a | b;
            3'd7:    res = a & b;
            default: res = a + b;
        endcase
        if (op == 7'h1b || op == 7'h3b) res = {{32{res[31]}}, res[31:0]};
        return res;
    endfunction

    always @(posedge clk) alu_data <= alu_fn(opcode, regB, regA_value, regB_value);

    typedef struct packed {
        logic [4:0]  ra;
        logic [11:0] rb;
        logic [9:0]  opc;
        logic [4:0]  rd;
        logic [63:0] av;
        logic [63:0] bv;
    } iss_t;
    localparam iss_t NopIss = '{ra: 5'd0, rb: 12'd0, opc: 10'h013, rd: 5'd0, av: '0, bv: '0};

    typedef struct {
        int         due;
        logic [4:0] rd;
    } ret_t;

    logic [63:0] mregs [32];
    ret_t        rq [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        rq.delete();
    endtask

    // In-order architectural semantics: operands come from the model registers at acceptance.
    task automatic model_accept(input logic [31:0] inst, output iss_t exp, output logic ill);
        logic [6:0]  op;
        logic        r;
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] res;
        ret_t        e;
        op = inst[6:0];
        r = (op == 7'h33) || (op == 7'h3b);
        exp = NopIss;
        ill = 1'b0;
        if (!(r || op == 7'h13 || op == 7'h1b)) begin
            ill = 1'b1;
        end else begin
            rs1 = inst[19:15];
            rs2 = inst[24:20];
            rd  = inst[11:7];
            exp.ra  = rs1;
            exp.rb  = inst[31:20];
            exp.opc = {inst[14:12], op};
            exp.rd  = rd;
            exp.av  = mregs[rs1];
            exp.bv  = r ? mregs[rs2] : 64'd0;
            res = alu_fn(exp.opc, exp.rb, exp.av, exp.bv);
            if (rd != 5'd0) mregs[rd] = res;
            e.due = cyc + 3;
            e.rd  = rd;
            rq.push_back(e);
        end
    endtask

    // One clock: decide acceptance before the edge, check everything after it.
    task automatic tick(output logic acc);
        iss_t exp;
        logic exp_ill, exp_ret;
        logic [4:0] exp_rd;
        #1;
        acc = inst_valid && inst_ready;
        exp = NopIss;
        exp_ill = 1'b0;
        if (acc) model_accept(inst_in, exp, exp_ill);
        @(negedge clk);
        cyc++;
        if (reset) begin
            model_reset();
            exp = NopIss;
            exp_ill = 1'b0;
        end
        exp_ret = (rq.size() > 0) && (rq[0].due == cyc);
        exp_rd  = exp_ret ? rq[0].rd : 5'd0;
        if (exp_ret) void'(rq.pop_front());
        chk("issue_fields", {regA, regB, opcode, regDest}, {exp.ra, exp.rb, exp.opc, exp.rd});
        chk("issue_values", {regA_value, regB_value}, {exp.av, exp.bv});
        chk("illegal", illegal, exp_ill);
        chk("retire", {retire, retire_rd}, {exp_ret, exp_rd});
    endtask

    task automatic idle(input int n);
        logic acc;
        inst_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic issue(input logic [31:0] inst, output int stalls);
        logic acc;
        bit done;
        inst_in = inst;
        inst_valid = 1'b1;
        stalls = 0;
        done = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            tick(acc);
            if (acc) done = 1;
            else stalls++;
        end
        if (!done) begin
            errors++;
            $display("FAIL issue_timeout: inst %h never accepted", inst);
        end
        inst_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        case ($urandom_range(0, 9))
            0, 1, 2: op = 7'h13;
            3, 4:    op = 7'h1b;
            5, 6, 7: op = 7'h33;
            8:       op = 7'h3b;
            default: op = ($urandom_range(0, 1) != 0) ? 7'h03 : 7'h6f;
        endcase
        case ($urandom_range(0, 3))
            0:       f3 = 3'd0;
            1:       f3 = 3'd4;
            2:       f3 = 3'd6;
            default: f3 = 3'd7;
        endcase
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        imm = 12'($urandom_range(0, 4095));
        f7  = (f3 == 3'd0 && $urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        if (op == 7'h33 || op == 7'h3b) return {f7, rs2, rs1, f3, rd, op};
        return {imm, rs1, f3, rd, op};
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  ra;
        logic [11:0] rb;
        logic [9:0]  opc;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int   st;
        logic acc;

        tbl[0] = '{32'h00500093, 5'd0, 12'h005, 10'h013, 5'd1,  1'b0};
        tbl[1] = '{32'h002081b3, 5'd1, 12'h002, 10'h033, 5'd3,  1'b0};
        tbl[2] = '{32'h401182b3, 5'd3, 12'h401, 10'h033, 5'd5,  1'b0};
        tbl[3] = '{32'hfff1021b, 5'd2, 12'hfff, 10'h01b, 5'd4,  1'b0};
        tbl[4] = '{32'h0020833b, 5'd1, 12'h002, 10'h03b, 5'd6,  1'b0};
        tbl[5] = '{32'h0000006f, 5'd0, 12'h000, 10'h013, 5'd0,  1'b1};
        tbl[6] = '{32'h00002083, 5'd0, 12'h000, 10'h013, 5'd0,  1'b1};
        tbl[7] = '{32'h0030e713, 5'd1, 12'h003, 10'h313, 5'd14, 1'b0};

        reset = 1'b1;
        inst_valid = 1'b0;
        inst_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_ready", inst_ready, 1'b0);
        chk("reset_outputs", {regA, regB, opcode, regDest, regA_value, regB_value},
            {5'd0, 12'd0, 10'h013, 5'd0, 64'd0, 64'd0});
        chk("reset_pulses", {illegal, retire, retire_rd}, 7'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", inst_ready, 1'b1);

        // Decode table.
        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].inst, st);
            chk("tbl_decode", {regA, regB, opcode, regDest, illegal},
                {tbl[i].ra, tbl[i].rb, tbl[i].opc, tbl[i].rd, tbl[i].ill});
        end
        idle(4);

        // addi x1,5 then read x1.
        issue(32'h00500093, st);
        idle(3);
        issue(32'h00008493, st);
        chk("read_x1", regA_value, 64'd5);
        idle(3);

        // add x3,x1,x2 with x1=7, x2=9.
        issue(32'h00700093, st);
        issue(32'h00900113, st);
        idle(3);
        issue(32'h002081b3, st);
        chk("add_operands", {regA_value, regB_value, opcode}, {64'd7, 64'd9, 10'h033});
        idle(3);
        issue(32'h00018513, st);
        chk("read_x3", regA_value, 64'd16);
        idle(3);

        // Back-to-back dependency.
        issue(32'h00100093, st);
        issue(32'h00108113, st);
        chk("dep_stalls", st, DepStalls);
        chk("dep_operand", regA_value, 64'd1);
        idle(3);
        issue(32'h00010593, st);
        chk("read_x2", regA_value, 64'd2);
        idle(3);

        // Write to x0 retires but never stalls x0 readers.
        issue(32'h00900013, st);
        issue(32'h00100613, st);
        chk("x0_no_stall", st, 0);
        chk("x0_reads_zero", regA_value, 64'd0);
        idle(3);

        // Illegal jal.
        issue(32'h0000006f, st);
        chk("jal_no_stall", st, 0);
        chk("jal_pulse", {illegal, opcode}, {1'b1, 10'h013});
        tick(acc);
        chk("jal_pulse_end", {illegal, inst_ready}, 2'b01);
        idle(3);

        // Reset with a write in flight.
        issue(32'h00300293, st);
        reset = 1'b1;
        tick(acc);
        chk("reset_kill_retire", retire, 1'b0);
        reset = 1'b0;
        #1;
        chk("ready_after_kill", inst_ready, 1'b1);
        idle(3);
        issue(32'h00028693, st);
        chk("x5_busy_clear", st, 0);
        chk("x5_dropped", regA_value, 64'd0);
        idle(3);

        // Random stream.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else issue(rand_inst(), st);
        end
        idle(4);
        chk("retire_queue_drained", rq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
